// File: rtl/bp_pkg.sv
// bp_pkg: opcode classes, branch metadata entry and control-opcode helper for branch resolution
package bp_pkg;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic        pred_br;
        logic [31:0] pred_target;
    } br_meta_t;
    function automatic logic is_ctrl(input logic [6:0] opcode);
        return opcode inside {OP_BRANCH, OP_JAL, OP_JALR};
    endfunction
endpackage

// File: rtl/br_meta_pipe.sv
// br_meta_pipe: DEPTH-stage IF-to-EX metadata shift register with stall hold and flush
module br_meta_pipe
    import bp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     stall,
    input  logic     flush,
    input  br_meta_t if_meta,
    output br_meta_t ex_meta
);
    br_meta_t [DEPTH-1:0] st;
    // a flush kills whatever shifts into every stage, so the EX entry retires and nothing younger survives
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= '0;
        end else if (!stall) begin
            st[0]       <= if_meta;
            st[0].valid <= if_meta.valid & ~flush;
            for (int i = 1; i < DEPTH; i++) begin
                st[i]       <= st[i-1];
                st[i].valid <= st[i-1].valid & ~flush;
            end
        end
    end
    assign ex_meta = st[DEPTH-1];
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage branch resolve, predictor update and redirect; perf counters under BP_PERF_CNT_EN
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int PERF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  if_valid,
    input  logic [31:0]           if_pc,
    input  logic [6:0]            if_opcode,
    input  logic                  if_pred_br,
    input  logic [31:0]           if_pred_target,
    input  logic                  ex_br_en,
    input  logic [31:0]           ex_target,
    output logic                  pred_ld,
    output logic [31:0]           write_pc,
    output logic                  cpu_br_en,
    output logic                  mispredict,
    output logic [31:0]           redirect_pc,
    output logic [PERF_WIDTH-1:0] perf_branches,
    output logic [PERF_WIDTH-1:0] perf_mispredicts
);
    br_meta_t ex;
    logic     is_br;
    logic     taken;
    br_meta_pipe #(.DEPTH(DEPTH)) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .flush   (mispredict),
        .if_meta ('{if_valid, if_pc, if_opcode, if_pred_br, if_pred_target}),
        .ex_meta (ex)
    );
    assign is_br       = ex.valid & (ex.opcode == OP_BRANCH);
    assign taken       = ex.valid & is_ctrl(ex.opcode) & (!is_br | ex_br_en);
    assign cpu_br_en   = taken;
    assign write_pc    = ex.valid ? ex.pc : '0;
    assign redirect_pc = !ex.valid ? '0 : taken ? ex_target : ex.pc + 32'd4;
    assign pred_ld     = is_br & ~stall;
    assign mispredict  = ex.valid & ~stall &
                         ((ex.pred_br != taken) | (ex.pred_br & taken & (ex.pred_target != ex_target)));
`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (pred_ld && !(&perf_branches)) perf_branches <= perf_branches + 1'b1;
            if (mispredict && !(&perf_mispredicts)) perf_mispredicts <= perf_mispredicts + 1'b1;
        end
    end
`else
    assign perf_branches    = '0;
    assign perf_mispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed checks of resolve, flush, stall, reset and perf counters at DEPTH=2
module tb_branch_resolve_unit;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, ALU = 7'b0110011;
    logic clk = 0, rst = 1, stall = 0, if_valid = 0, if_pred_br = 0, ex_br_en = 0;
    logic [31:0] if_pc = 0, if_pred_target = 0, ex_target = 0;
    logic [6:0]  if_opcode = 0;
    logic        pred_ld, cpu_br_en, mispredict;
    logic [31:0] write_pc, redirect_pc, perf_branches, perf_mispredicts;
    int total = 0, bad = 0, n_br = 0, n_mis = 0;
    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(2), .PERF_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
        .if_opcode(if_opcode), .if_pred_br(if_pred_br), .if_pred_target(if_pred_target),
        .ex_br_en(ex_br_en), .ex_target(ex_target), .pred_ld(pred_ld), .write_pc(write_pc),
        .cpu_br_en(cpu_br_en), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    function automatic logic [66:0] obs();
        return {pred_ld, cpu_br_en, mispredict, write_pc, redirect_pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [6:0] op,
                         input logic pb, input logic [31:0] pt);
        if_valid = v; if_pc = pc; if_opcode = op; if_pred_br = pb; if_pred_target = pt;
    endtask

    // retire whatever is at EX, then walk one instruction from IF to EX behind a bubble
    task automatic to_ex(input logic [31:0] pc, input logic [6:0] op, input logic pb, input logic [31:0] pt);
        drive(0, 0, 0, 0, 0); tick();
        drive(1, pc, op, pb, pt); tick();
        drive(0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_reset();
        rst = 1; tick(); tick(); rst = 0; #1;
        total++;
        if (obs() !== 67'd0) begin bad++; $display("FAIL reset_outs got=%h exp=0", obs()); end
        total++;
        if ({perf_branches, perf_mispredicts} !== 64'd0) begin
            bad++; $display("FAIL reset_perf got=%h/%h exp=0/0", perf_branches, perf_mispredicts);
        end
    endtask

    task automatic test_mispredict_taken();
        drive(0, 0, 0, 0, 0); tick();
        drive(1, 32'h100, BR, 0, 0); tick();
        drive(1, 32'h800, BR, 0, 0); tick();
        drive(1, 32'h900, BR, 1, 32'h990);
        ex_br_en = 1; ex_target = 32'h180; #1;
        total++;
        if (obs() !== {1'b1, 1'b1, 1'b1, 32'h100, 32'h180}) begin
            bad++; $display("FAIL mp_taken got=%h exp=%h", obs(), {1'b1, 1'b1, 1'b1, 32'h100, 32'h180});
        end
        n_br++; n_mis++;
        tick(); drive(0, 0, 0, 0, 0); #1;
        total++;
        if (obs() !== 67'd0) begin bad++; $display("FAIL flush_s1 got=%h exp=0", obs()); end
        tick();
        total++;
        if (obs() !== 67'd0) begin bad++; $display("FAIL flush_if got=%h exp=0", obs()); end
    endtask

    task automatic test_correct();
        to_ex(32'h200, BR, 1, 32'h240);
        ex_br_en = 1; ex_target = 32'h240; #1;
        total++;
        if (obs() !== {1'b1, 1'b1, 1'b0, 32'h200, 32'h240}) begin
            bad++; $display("FAIL correct got=%h exp=%h", obs(), {1'b1, 1'b1, 1'b0, 32'h200, 32'h240});
        end
        n_br++;
    endtask

    task automatic test_not_taken();
        to_ex(32'h300, BR, 1, 32'h350);
        ex_br_en = 0; ex_target = 32'h350; #1;
        total++;
        if (obs() !== {1'b1, 1'b0, 1'b1, 32'h300, 32'h304}) begin
            bad++; $display("FAIL not_taken got=%h exp=%h", obs(), {1'b1, 1'b0, 1'b1, 32'h300, 32'h304});
        end
        n_br++; n_mis++;
        to_ex(32'hFFFF_FFFC, BR, 1, 32'h10);
        ex_br_en = 0; ex_target = 32'h10; #1;
        total++;
        if (obs() !== {1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0}) begin
            bad++; $display("FAIL pc_wrap got=%h exp=%h", obs(), {1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0});
        end
        n_br++; n_mis++;
    endtask

    task automatic test_jumps();
        to_ex(32'h400, JALR, 1, 32'h500);
        ex_br_en = 0; ex_target = 32'h520; #1;
        total++;
        if (obs() !== {1'b0, 1'b1, 1'b1, 32'h400, 32'h520}) begin
            bad++; $display("FAIL jalr_tgt got=%h exp=%h", obs(), {1'b0, 1'b1, 1'b1, 32'h400, 32'h520});
        end
        n_mis++;
        to_ex(32'h440, JAL, 1, 32'h600);
        ex_br_en = 0; ex_target = 32'h600; #1;
        total++;
        if (obs() !== {1'b0, 1'b1, 1'b0, 32'h440, 32'h600}) begin
            bad++; $display("FAIL jal_ok got=%h exp=%h", obs(), {1'b0, 1'b1, 1'b0, 32'h440, 32'h600});
        end
        to_ex(32'h480, ALU, 0, 0);
        ex_br_en = 1; ex_target = 32'h777; #1;
        total++;
        if (obs() !== {1'b0, 1'b0, 1'b0, 32'h480, 32'h484}) begin
            bad++; $display("FAIL alu got=%h exp=%h", obs(), {1'b0, 1'b0, 1'b0, 32'h480, 32'h484});
        end
    endtask

    task automatic test_stall();
        to_ex(32'h600, BR, 0, 0);
        ex_br_en = 1; ex_target = 32'h680; stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (obs() !== {1'b0, 1'b1, 1'b0, 32'h600, 32'h680}) begin
                bad++; $display("FAIL stall_%0d got=%h exp=%h", i, obs(), {1'b0, 1'b1, 1'b0, 32'h600, 32'h680});
            end
            tick();
        end
        stall = 0; #1;
        total++;
        if (obs() !== {1'b1, 1'b1, 1'b1, 32'h600, 32'h680}) begin
            bad++; $display("FAIL stall_release got=%h exp=%h", obs(), {1'b1, 1'b1, 1'b1, 32'h600, 32'h680});
        end
        n_br++; n_mis++;
        tick();
        total++;
        if (obs() !== 67'd0) begin bad++; $display("FAIL stall_once got=%h exp=0", obs()); end
    endtask

    task automatic test_perf();
        logic [31:0] eb, em;
`ifdef BP_PERF_CNT_EN
        eb = n_br; em = n_mis;
`else
        eb = 0; em = 0;
`endif
        drive(0, 0, 0, 0, 0); tick();
        total++;
        if (perf_branches !== eb) begin bad++; $display("FAIL perf_br got=%0d exp=%0d", perf_branches, eb); end
        total++;
        if (perf_mispredicts !== em) begin bad++; $display("FAIL perf_mis got=%0d exp=%0d", perf_mispredicts, em); end
    endtask

    task automatic test_reset_mid();
        drive(1, 32'h700, BR, 1, 32'h7f0); tick();
        drive(1, 32'h710, BR, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        ex_br_en = 1; ex_target = 32'h999;
        rst = 1; tick(); rst = 0; #1;
        total++;
        if (obs() !== 67'd0) begin bad++; $display("FAIL rst_mid got=%h exp=0", obs()); end
        tick();
        total++;
        if (obs() !== 67'd0) begin bad++; $display("FAIL rst_mid2 got=%h exp=0", obs()); end
        total++;
        if ({perf_branches, perf_mispredicts} !== 64'd0) begin
            bad++; $display("FAIL rst_mid_perf got=%h/%h exp=0/0", perf_branches, perf_mispredicts);
        end
    endtask

    initial begin
        test_reset();
        test_mispredict_taken();
        test_correct();
        test_not_taken();
        test_jumps();
        test_stall();
        test_perf();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
